// File: rtl/tx_fifo.sv
// ============================================================================
// Module      : tx_fifo
// Description : Transmit FIFO with first-word-fall-through output and an
//               edge-triggered pop. The optional sticky overflow flag is
//               enabled by defining the macro TX_FIFO_OVERFLOW_FLAG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 9
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     clear_fifo,
  input  logic                     data_request,
  input  logic                     overflow_clear,
  output logic [WIDTH-1:0]         data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int                 c_AW   = $clog2(DEPTH);
  localparam logic [c_AW:0]      c_FULL = (c_AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_AW:0]    r_count;
  logic             r_req_d;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_wr;
  logic w_drop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_FULL);
  // A held-high request pops once; a pop on an empty FIFO is simply ignored.
  assign w_pop   = data_request & ~r_req_d & ~w_empty;
  // The same-cycle pop frees a slot, so a write at full is still accepted.
  assign w_wr    = wr_en & (~w_full | w_pop);
  assign w_drop  = wr_en & w_full & ~w_pop;

  always_ff @(posedge clock) begin
    if (reset && !clear_fifo && w_wr) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_req_d  <= 1'b0;
    end else begin
      r_req_d <= data_request;
      if (clear_fifo) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_wr) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
        case ({w_wr, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

`ifdef TX_FIFO_OVERFLOW_FLAG_EN
  logic r_overflow;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_overflow <= 1'b0;
    end else if (overflow_clear) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

  assign overflow = r_overflow;
`else
  logic w_unused_ovf;
  assign w_unused_ovf = overflow_clear | w_drop;
  assign overflow     = 1'b0;
`endif

  assign data  = r_mem[r_rd_ptr];
  assign empty = w_empty;
  assign full  = w_full;
  assign count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_tx_fifo.sv
// Testbench for tx_fifo: directed scenarios plus random traffic, compared
// cycle by cycle against a queue-based reference model.
`default_nettype none

module tb_tx_fifo;

  localparam int DEPTH = 16;
  localparam int WIDTH = 9;

  logic             clock = 1'b0;
  logic             reset;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             clear_fifo;
  logic             data_request;
  logic             overflow_clear;
  logic [WIDTH-1:0] data;
  logic             empty;
  logic             full;
  logic [4:0]       count;
  logic             overflow;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] model_q[$];
  bit               m_prev_req;
  bit               m_ovf;

  tx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clock          (clock),
    .reset          (reset),
    .wr_en          (wr_en),
    .wr_data        (wr_data),
    .clear_fifo     (clear_fifo),
    .data_request   (data_request),
    .overflow_clear (overflow_clear),
    .data           (data),
    .empty          (empty),
    .full           (full),
    .count          (count),
    .overflow       (overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: occupancy is the queue length; the head is q[0].
  task automatic model_step(input bit rst_n, input bit w, input logic [WIDTH-1:0] wd,
                            input bit clr, input bit req, input bit oc);
    int sz;
    bit pop, accept, drop;
    sz     = model_q.size();
    pop    = req && !m_prev_req && (sz > 0);
    accept = w && ((sz < DEPTH) || pop);
    drop   = w && (sz == DEPTH) && !pop;
    if (!rst_n) begin
      model_q.delete();
      m_prev_req = 0;
      m_ovf      = 0;
    end else begin
`ifdef TX_FIFO_OVERFLOW_FLAG_EN
      if (oc) m_ovf = 0;
      else if (drop) m_ovf = 1;
`endif
      m_prev_req = req;
      if (clr) begin
        model_q.delete();
      end else begin
        if (pop) model_q.delete(0);
        if (accept) model_q.push_back(wd);
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_count"}, 32'(count), 32'(model_q.size()));
    check({tag, "_empty"}, 32'(empty), 32'(model_q.size() == 0));
    check({tag, "_full"}, 32'(full), 32'(model_q.size() == DEPTH));
    check({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
    if (model_q.size() > 0) check({tag, "_data"}, 32'(data), 32'(model_q[0]));
  endtask

  task automatic cycle(input string tag, input bit rst_n, input bit w,
                       input logic [WIDTH-1:0] wd, input bit clr, input bit req, input bit oc);
    reset          = rst_n;
    wr_en          = w;
    wr_data        = wd;
    clear_fifo     = clr;
    data_request   = req;
    overflow_clear = oc;
    model_step(rst_n, w, wd, clr, req, oc);
    @(posedge clock);
    #1;
    check_all(tag);
  endtask

  initial begin
    reset = 0; wr_en = 0; wr_data = '0; clear_fifo = 0; data_request = 0; overflow_clear = 0;

    // Reset, with data_request already high at release: that edge hits an empty FIFO.
    cycle("rst", 0, 0, 0, 0, 1, 0);
    cycle("rst", 0, 0, 0, 0, 1, 0);
    check("rst_empty_const", 32'(empty), 1);
    check("rst_count_const", 32'(count), 0);
    cycle("rel", 1, 0, 0, 0, 1, 0);
    cycle("rel", 1, 0, 0, 0, 0, 0);

    // Two writes, then one request edge.
    cycle("w1", 1, 1, 9'h055, 0, 0, 0);
    cycle("w2", 1, 1, 9'h1A3, 0, 0, 0);
    check("two_count", 32'(count), 2);
    check("two_data", 32'(data), 32'h055);
    cycle("pop1", 1, 0, 0, 0, 1, 0);
    check("pop1_data", 32'(data), 32'h1A3);
    check("pop1_count", 32'(count), 1);
    cycle("idle", 1, 0, 0, 0, 0, 0);

    // 17 writes into an emptied FIFO: the last is dropped.
    cycle("clr", 1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 17; i++) cycle("fill", 1, 1, 9'(i + 9'h100), 0, 0, 0);
    check("fill_full", 32'(full), 1);
    check("fill_count", 32'(count), 16);
    check("fill_head", 32'(data), 32'h100);
    cycle("ovclr", 1, 0, 0, 0, 0, 1);
    check("ovclr_ovf", 32'(overflow), 0);

    // Write + pop at full keeps count at DEPTH without overflow.
    cycle("fullwp", 1, 1, 9'h0AA, 0, 1, 0);
    check("fullwp_count", 32'(count), 16);
    cycle("idle", 1, 0, 0, 0, 0, 0);

    // Three words, request held for 10 cycles: one pop only.
    cycle("clr", 1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cycle("w3", 1, 1, 9'(i * 7 + 3), 0, 0, 0);
    for (int i = 0; i < 10; i++) cycle("hold", 1, 0, 0, 0, 1, 0);
    check("hold_count", 32'(count), 2);
    cycle("idle", 1, 0, 0, 0, 0, 0);

    // Write + pop at empty: only the write takes effect.
    cycle("clr", 1, 0, 0, 1, 0, 0);
    cycle("emptywp", 1, 1, 9'h1C5, 0, 1, 0);
    check("emptywp_count", 32'(count), 1);
    check("emptywp_data", 32'(data), 32'h1C5);
    cycle("idle", 1, 0, 0, 0, 0, 0);

    // Clear with count 5 and a same-cycle write.
    cycle("clr", 1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) cycle("w5", 1, 1, 9'(i + 9'h040), 0, 0, 0);
    cycle("clrw", 1, 1, 9'h0EE, 1, 0, 0);
    check("clrw_count", 32'(count), 0);
    check("clrw_empty", 32'(empty), 1);

    // 40 write/pop pairs wrap both pointers.
    for (int i = 0; i < 40; i++) begin
      cycle("pair_w", 1, 1, 9'($urandom), 0, 0, 0);
      cycle("pair_p", 1, 0, 0, 0, 1, 0);
      cycle("pair_l", 1, 0, 0, 0, 0, 0);
    end

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cycle("rand", 1, ($urandom_range(9, 0) < 6), 9'($urandom),
            ($urandom_range(49, 0) == 0), $urandom_range(1, 0),
            ($urandom_range(19, 0) == 0));
    end

    // Reset in the middle of traffic discards everything.
    for (int i = 0; i < 6; i++) cycle("pre_rst", 1, 1, 9'($urandom), 0, 0, 0);
    cycle("midrst", 0, 1, 9'h111, 0, 1, 0);
    check("midrst_empty", 32'(empty), 1);
    cycle("post", 1, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
